tick_period_meter: RTL

// - Receiving end of the divided-clock path: takes a slow tick/clock produced by a frequency divider (or any slow square wave) and measures its period in fast-clock cycles.
// - Synchronises the input, detects rising edges, counts cycles between consecutive edges, and hands each result to the consumer over a valid/ack handshake.
// - Used to verify divider ratios in-system and to drive period-dependent display/control logic.

---
 rtl/tick_period_meter_pkg.sv | 14 +
 rtl/tick_period_meter_sync_edge_detect.sv | 28 ++
 rtl/tick_period_meter.sv | 97 +++++++++
 3 files changed

// File: rtl/tick_period_meter_pkg.sv
// Shared definitions for the tick period meter: FSM state encoding and
// default sizing for the period counter and input synchroniser.
package tick_period_meter_pkg;

  localparam int CNT_W_DEFAULT       = 17;
  localparam int SYNC_STAGES_DEFAULT = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_MEASURE = 2'd2
  } state_t;

endpackage

// File: rtl/tick_period_meter_sync_edge_detect.sv
// Brings the asynchronous slow tick into the clk domain and turns each
// rising edge of it into a registered single-cycle pulse.
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic sig_in,
  output logic edge_pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_d;

  // sync_q[SYNC_STAGES-1] is the first metastability-safe copy of sig_in
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q     <= '0;
      s_d        <= 1'b0;
      edge_pulse <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], sig_in};
      s_d        <= sync_q[SYNC_STAGES-1];
      edge_pulse <= sync_q[SYNC_STAGES-1] & ~s_d;
    end
  end

endmodule

// File: rtl/tick_period_meter.sv
// Measures the period of a slow tick in clk cycles and offers each result
// to a consumer over a valid/ack handshake, flagging drops and timeouts.
module tick_period_meter
  import tick_period_meter_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEFAULT,
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period_out,
  output logic             period_valid,
  input  logic             period_ack,
  output logic             overrun,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             edge_pulse;
  logic             capture;

  sync_edge_detect #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge_detect (
    .clk        (clk),
    .reset      (reset),
    .sig_in     (sig_in),
    .edge_pulse (edge_pulse)
  );

  assign capture = enable && (state == ST_MEASURE) && edge_pulse;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      period_out   <= '0;
      period_valid <= 1'b0;
      overrun      <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      // The result register keeps serving the consumer even while disabled
      if (capture) begin
        if (!period_valid || period_ack) begin
          period_out   <= cnt;
          period_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (period_ack) begin
        period_valid <= 1'b0;
      end

      if (!enable) begin
        state   <= ST_IDLE;
        cnt     <= '0;
        overrun <= 1'b0;
        timeout <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            cnt   <= '0;
            state <= ST_ARM;
          end
          ST_ARM: begin
            if (edge_pulse) begin
              cnt   <= {{(CNT_W-1){1'b0}}, 1'b1};
              state <= ST_MEASURE;
            end
          end
          ST_MEASURE: begin
            // An edge on the last countable cycle still yields a valid result
            if (edge_pulse) begin
              cnt <= {{(CNT_W-1){1'b0}}, 1'b1};
            end else if (cnt == CNT_MAX) begin
              timeout <= 1'b1;
              cnt     <= '0;
              state   <= ST_ARM;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            cnt   <= '0;
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule
